// File: rtl/fwd_scoreboard_pkg.sv
// Shared forwarding-select encodings and default widths
// for the operand forwarding scoreboard.
package fwd_scoreboard_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_AW = 4;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/fwd_port_mux.sv
// One ID read port: youngest-first match against EX, MEM
// and WB destinations, with zeroed data when no match.
module fwd_port_mux
  import fwd_scoreboard_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int ZERO_REG = 0
) (
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_en,
  input  logic [AW-1:0] dst_addr_ex,
  input  logic [AW-1:0] dst_addr_mem,
  input  logic [AW-1:0] dst_addr_wb,
  input  logic          we_ex,
  input  logic          we_mem,
  input  logic          we_wb,
  input  logic [DW-1:0] dst_ex,
  input  logic [DW-1:0] dst_mem,
  input  logic [DW-1:0] dst_wb,
  output logic [1:0]    sel,
  output logic [DW-1:0] data
);

  logic zero_rd;
  logic live;

  assign zero_rd = (ZERO_REG != 0) && (rd_addr == '0);
  assign live    = rd_en && !zero_rd;

  always_comb begin
    sel  = FWD_RF;
    data = '0;
    if (live) begin
      if (we_ex && dst_addr_ex == rd_addr) begin
        sel  = FWD_EX;
        data = dst_ex;
      end else if (we_mem && dst_addr_mem == rd_addr) begin
        sel  = FWD_MEM;
        data = dst_mem;
      end else if (we_wb && dst_addr_wb == rd_addr) begin
        sel  = FWD_WB;
        data = dst_wb;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand forwarding plus busy-bit scoreboard for
// long-latency ops, load-use stall and stall counter.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int NP       = 2,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NP*AW-1:0] rd_addr_id,
  input  logic [NP-1:0]    rd_en_id,
  input  logic [AW-1:0]    dst_addr_ex,
  input  logic [AW-1:0]    dst_addr_mem,
  input  logic [AW-1:0]    dst_addr_wb,
  input  logic             we_ex,
  input  logic             we_mem,
  input  logic             we_wb,
  input  logic [DW-1:0]    dst_ex,
  input  logic [DW-1:0]    dst_mem,
  input  logic [DW-1:0]    dst_wb,
  input  logic             ex_is_load,
  input  logic             long_issue,
  input  logic [AW-1:0]    long_issue_addr,
  input  logic             long_done,
  input  logic             cnt_clr,
  output logic [NP*2-1:0]  fwd_sel,
  output logic [NP*DW-1:0] fwd_data,
  output logic             stall_id,
  output logic [15:0]      stall_cnt,
  output logic             sb_err
);

  localparam int NR = 1 << AW;

  logic [NR-1:0] busy;
  logic [NR-1:0] busy_nxt;
  logic [NP-1:0] port_stall;
  logic          wb_done;
  logic          waw;
  logic          zero_issue;
  logic          issue_ok;
  logic          done_ok;
  logic          err_set;

  for (genvar g = 0; g < NP; g++) begin : g_port
    fwd_port_mux #(
      .DW       (DW),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_mux (
      .rd_addr      (rd_addr_id[g*AW +: AW]),
      .rd_en        (rd_en_id[g]),
      .dst_addr_ex  (dst_addr_ex),
      .dst_addr_mem (dst_addr_mem),
      .dst_addr_wb  (dst_addr_wb),
      .we_ex        (we_ex),
      .we_mem       (we_mem),
      .we_wb        (we_wb),
      .dst_ex       (dst_ex),
      .dst_mem      (dst_mem),
      .dst_wb       (dst_wb),
      .sel          (fwd_sel[g*2 +: 2]),
      .data         (fwd_data[g*DW +: DW])
    );
  end

  assign wb_done = long_done && we_wb;

  // A busy source is released early when WB retires its long op now.
  always_comb begin
    port_stall = '0;
    for (int k = 0; k < NP; k++) begin
      if (rd_en_id[k]) begin
        if (fwd_sel[k*2 +: 2] == FWD_EX && ex_is_load)
          port_stall[k] = 1'b1;
        if (busy[rd_addr_id[k*AW +: AW]] &&
            !(wb_done && dst_addr_wb == rd_addr_id[k*AW +: AW]))
          port_stall[k] = 1'b1;
      end
    end
  end

  assign zero_issue = (ZERO_REG != 0) && (long_issue_addr == '0);
  assign waw        = long_issue && busy[long_issue_addr];
  assign stall_id   = (|port_stall) || waw;
  assign issue_ok   = long_issue && !stall_id && !zero_issue;
  assign done_ok    = wb_done && busy[dst_addr_wb];
  assign err_set    = long_done && !done_ok;

  // Set after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    busy_nxt = busy;
    if (done_ok)
      busy_nxt[dst_addr_wb] = 1'b0;
    if (issue_ok)
      busy_nxt[long_issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_err <= 1'b0;
    end else if (err_set) begin
      sb_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall_id && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: vector table, directed
// multi-cycle sequences and a randomized model run.
module tb_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rd_addr_id;
  logic [1:0]  rd_en_id;
  logic [3:0]  dst_addr_ex, dst_addr_mem, dst_addr_wb;
  logic        we_ex, we_mem, we_wb;
  logic [15:0] dst_ex, dst_mem, dst_wb;
  logic        ex_is_load, long_issue, long_done, cnt_clr;
  logic [3:0]  long_issue_addr;

  logic [3:0]  fwd_sel, z_sel;
  logic [31:0] fwd_data, z_data;
  logic        stall_id, z_stall;
  logic [15:0] stall_cnt, z_cnt;
  logic        sb_err, z_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fwd_scoreboard #(.DW(16), .AW(4), .NP(2), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .rd_addr_id(rd_addr_id), .rd_en_id(rd_en_id),
    .dst_addr_ex(dst_addr_ex), .dst_addr_mem(dst_addr_mem),
    .dst_addr_wb(dst_addr_wb), .we_ex(we_ex), .we_mem(we_mem),
    .we_wb(we_wb), .dst_ex(dst_ex), .dst_mem(dst_mem), .dst_wb(dst_wb),
    .ex_is_load(ex_is_load), .long_issue(long_issue),
    .long_issue_addr(long_issue_addr), .long_done(long_done),
    .cnt_clr(cnt_clr), .fwd_sel(fwd_sel), .fwd_data(fwd_data),
    .stall_id(stall_id), .stall_cnt(stall_cnt), .sb_err(sb_err)
  );

  fwd_scoreboard #(.DW(16), .AW(4), .NP(2), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .rd_addr_id(rd_addr_id), .rd_en_id(rd_en_id),
    .dst_addr_ex(dst_addr_ex), .dst_addr_mem(dst_addr_mem),
    .dst_addr_wb(dst_addr_wb), .we_ex(we_ex), .we_mem(we_mem),
    .we_wb(we_wb), .dst_ex(dst_ex), .dst_mem(dst_mem), .dst_wb(dst_wb),
    .ex_is_load(ex_is_load), .long_issue(long_issue),
    .long_issue_addr(long_issue_addr), .long_done(long_done),
    .cnt_clr(cnt_clr), .fwd_sel(z_sel), .fwd_data(z_data),
    .stall_id(z_stall), .stall_cnt(z_cnt), .sb_err(z_err)
  );

  typedef struct packed {
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [1:0]  en;
    logic [2:0]  we;
    logic        load;
    logic [3:0]  aex;
    logic [3:0]  amem;
    logic [3:0]  awb;
    logic [1:0]  s0;
    logic [15:0] d0;
    logic [1:0]  s1;
    logic [15:0] d1;
    logic        st;
  } vec_t;

  vec_t tbl [8];

  // Registers holding long ops that have not yet retired.
  int pend[$];
  int mcnt;
  bit merr;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rd_addr_id = '0; rd_en_id = '0;
    dst_addr_ex = '0; dst_addr_mem = '0; dst_addr_wb = '0;
    we_ex = 0; we_mem = 0; we_wb = 0;
    dst_ex = 16'hAAAA; dst_mem = 16'hBBBB; dst_wb = 16'hCCCC;
    ex_is_load = 0; long_issue = 0; long_issue_addr = '0;
    long_done = 0; cnt_clr = 0;
  endtask

  task automatic set_vec(input vec_t v);
    idle();
    rd_addr_id = {v.ra1, v.ra0};
    rd_en_id = v.en;
    {we_ex, we_mem, we_wb} = v.we;
    ex_is_load = v.load;
    dst_addr_ex = v.aex; dst_addr_mem = v.amem; dst_addr_wb = v.awb;
    cnt_clr = 1;
  endtask

  function automatic bit busy_m(input int a);
    foreach (pend[i]) if (pend[i] == a) return 1;
    return 0;
  endfunction

  function automatic void mport(input int k, output logic [1:0] s,
                                output logic [15:0] d);
    logic [3:0] a;
    a = rd_addr_id[k*4 +: 4];
    s = 0; d = 0;
    if (!rd_en_id[k]) return;
    if (we_ex && dst_addr_ex == a) begin s = 1; d = dst_ex; end
    else if (we_mem && dst_addr_mem == a) begin s = 2; d = dst_mem; end
    else if (we_wb && dst_addr_wb == a) begin s = 3; d = dst_wb; end
  endfunction

  function automatic bit mstall();
    logic [1:0]  s;
    logic [15:0] d;
    logic [3:0]  a;
    bit st = 0;
    for (int k = 0; k < 2; k++) begin
      mport(k, s, d);
      a = rd_addr_id[k*4 +: 4];
      if (rd_en_id[k]) begin
        if (s == 1 && ex_is_load) st = 1;
        if (busy_m(a) && !(long_done && we_wb && dst_addr_wb == a)) st = 1;
      end
    end
    if (long_issue && busy_m(long_issue_addr)) st = 1;
    return st;
  endfunction

  task automatic model_step(input bit st);
    bit hit;
    hit = long_done && we_wb && busy_m(dst_addr_wb);
    if (long_done && !hit) merr = 1;
    if (hit)
      for (int i = 0; i < pend.size(); i++)
        if (pend[i] == dst_addr_wb) begin pend.delete(i); break; end
    if (long_issue && !st && !busy_m(long_issue_addr))
      pend.push_back(int'(long_issue_addr));
    if (cnt_clr) mcnt = 0;
    else if (st && mcnt < 65535) mcnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle();
    #2 rst = 0;
    pend.delete(); mcnt = 0; merr = 0;
  endtask

  initial begin
    logic [1:0]  es;
    logic [15:0] ed;
    bit          est;
    int          r;

    rst = 1;
    idle();
    tbl[0] = '{4'd3, 4'd0, 2'b01, 3'b110, 1'b0, 4'd3, 4'd3, 4'd0,
               2'd1, 16'hAAAA, 2'd0, 16'h0, 1'b0};
    tbl[1] = '{4'd6, 4'd0, 2'b01, 3'b011, 1'b0, 4'd6, 4'd6, 4'd6,
               2'd2, 16'hBBBB, 2'd0, 16'h0, 1'b0};
    tbl[2] = '{4'd6, 4'd6, 2'b11, 3'b001, 1'b0, 4'd0, 4'd0, 4'd6,
               2'd3, 16'hCCCC, 2'd3, 16'hCCCC, 1'b0};
    tbl[3] = '{4'd1, 4'd2, 2'b11, 3'b111, 1'b0, 4'd4, 4'd5, 4'd6,
               2'd0, 16'h0, 2'd0, 16'h0, 1'b0};
    tbl[4] = '{4'd4, 4'd9, 2'b10, 3'b100, 1'b1, 4'd4, 4'd0, 4'd0,
               2'd0, 16'h0, 2'd0, 16'h0, 1'b0};
    tbl[5] = '{4'd0, 4'd5, 2'b10, 3'b100, 1'b1, 4'd5, 4'd0, 4'd0,
               2'd0, 16'h0, 2'd1, 16'hAAAA, 1'b1};
    tbl[6] = '{4'd7, 4'd0, 2'b01, 3'b010, 1'b1, 4'd7, 4'd7, 4'd0,
               2'd2, 16'hBBBB, 2'd0, 16'h0, 1'b0};
    tbl[7] = '{4'd8, 4'd9, 2'b11, 3'b110, 1'b0, 4'd9, 4'd8, 4'd0,
               2'd2, 16'hBBBB, 2'd1, 16'hAAAA, 1'b0};

    #3;
    check("rst_sel", {28'd0, fwd_sel}, 0);
    check("rst_data", fwd_data, 0);
    check("rst_stall", {31'd0, stall_id}, 0);
    check("rst_cnt", {16'd0, stall_cnt}, 0);
    check("rst_err", {31'd0, sb_err}, 0);
    @(negedge clk);
    rst = 0;

    foreach (tbl[i]) begin
      @(negedge clk);
      set_vec(tbl[i]);
      #1;
      check($sformatf("tbl%0d_sel0", i), {30'd0, fwd_sel[1:0]}, {30'd0, tbl[i].s0});
      check($sformatf("tbl%0d_data0", i), {16'd0, fwd_data[15:0]}, {16'd0, tbl[i].d0});
      check($sformatf("tbl%0d_sel1", i), {30'd0, fwd_sel[3:2]}, {30'd0, tbl[i].s1});
      check($sformatf("tbl%0d_data1", i), {16'd0, fwd_data[31:16]}, {16'd0, tbl[i].d1});
      check($sformatf("tbl%0d_stall", i), {31'd0, stall_id}, {31'd0, tbl[i].st});
    end

    // Load-use counted once
    @(negedge clk);
    set_vec(tbl[5]);
    cnt_clr = 0;
    #1 check("lu_stall", {31'd0, stall_id}, 1);
    @(negedge clk);
    check("lu_cnt", {16'd0, stall_cnt}, 1);
    idle();

    // Long op issue, busy stall, WB release
    long_issue = 1; long_issue_addr = 4'd7;
    #1 check("li_issue_stall", {31'd0, stall_id}, 0);
    @(negedge clk);
    idle();
    rd_addr_id = 8'h07; rd_en_id = 2'b01;
    #1 check("busy_stall", {31'd0, stall_id}, 1);
    check("busy_sel", {28'd0, fwd_sel}, 0);
    @(negedge clk);
    long_done = 1; we_wb = 1; dst_addr_wb = 4'd7; dst_wb = 16'h1234;
    #1 check("rel_sel", {30'd0, fwd_sel[1:0]}, 3);
    check("rel_data", {16'd0, fwd_data[15:0]}, 32'h1234);
    check("rel_stall", {31'd0, stall_id}, 0);
    @(negedge clk);
    idle();
    rd_addr_id = 8'h07; rd_en_id = 2'b01;
    #1 check("cleared_stall", {31'd0, stall_id}, 0);
    check("no_err", {31'd0, sb_err}, 0);

    // WAW stall
    @(negedge clk);
    idle();
    long_issue = 1; long_issue_addr = 4'd10;
    @(negedge clk);
    #1 check("waw_stall", {31'd0, stall_id}, 1);
    @(negedge clk);
    idle();
    long_done = 1; we_wb = 1; dst_addr_wb = 4'd10;
    @(negedge clk);
    idle();
    rd_addr_id = 8'h0A; rd_en_id = 2'b01;
    #1 check("waw_clear", {31'd0, stall_id}, 0);
    check("waw_err", {31'd0, sb_err}, 0);

    // Register zero handling
    @(negedge clk);
    idle();
    we_ex = 1; dst_addr_ex = 4'd0; rd_en_id = 2'b01;
    #1 check("z_sel", {28'd0, z_sel}, 0);
    check("z_data", z_data, 0);
    check("nz_sel", {30'd0, fwd_sel[1:0]}, 1);
    check("nz_data", {16'd0, fwd_data[15:0]}, 32'hAAAA);
    @(negedge clk);
    idle();
    long_issue = 1; long_issue_addr = 4'd0;
    @(negedge clk);
    idle();
    rd_en_id = 2'b01;
    #1 check("z_busy", {31'd0, z_stall}, 0);
    check("nz_busy", {31'd0, stall_id}, 1);

    // Retire to an idle register
    do_reset();
    @(negedge clk);
    long_done = 1; we_wb = 1; dst_addr_wb = 4'd9;
    @(negedge clk);
    idle();
    check("err_set", {31'd0, sb_err}, 1);
    repeat (3) @(negedge clk);
    check("err_sticky", {31'd0, sb_err}, 1);

    // Randomized run against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      check("rnd_cnt", {16'd0, stall_cnt}, mcnt);
      check("rnd_err", {31'd0, sb_err}, {31'd0, merr});
      rd_addr_id = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
      rd_en_id = 2'($urandom);
      we_ex = 1'($urandom); we_mem = 1'($urandom); we_wb = 1'($urandom);
      dst_addr_ex = 4'($urandom_range(0, 5));
      dst_addr_mem = 4'($urandom_range(0, 5));
      dst_addr_wb = 4'($urandom_range(0, 5));
      dst_ex = 16'($urandom); dst_mem = 16'($urandom); dst_wb = 16'($urandom);
      ex_is_load = ($urandom_range(0, 3) == 0);
      long_issue = ($urandom_range(0, 3) == 0);
      long_issue_addr = 4'($urandom_range(0, 5));
      cnt_clr = ($urandom_range(0, 19) == 0);
      long_done = 0;
      r = $urandom_range(0, 199);
      if (r < 60 && pend.size() > 0) begin
        long_done = 1; we_wb = 1;
        dst_addr_wb = 4'(pend[$urandom_range(0, pend.size() - 1)]);
      end else if (r == 60) begin
        long_done = 1;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        mport(k, es, ed);
        check($sformatf("rnd_sel%0d", k), {30'd0, fwd_sel[k*2 +: 2]}, {30'd0, es});
        check($sformatf("rnd_data%0d", k), {16'd0, fwd_data[k*16 +: 16]}, {16'd0, ed});
      end
      est = mstall();
      check("rnd_stall", {31'd0, stall_id}, {31'd0, est});
      model_step(est);
    end

    // Saturation and asynchronous reset mid-run
    do_reset();
    @(negedge clk);
    long_issue = 1; long_issue_addr = 4'd2;
    @(negedge clk);
    idle();
    long_done = 1; dst_addr_wb = 4'd9;
    @(negedge clk);
    idle();
    we_ex = 1; ex_is_load = 1; dst_addr_ex = 4'd5;
    rd_addr_id = 8'h50; rd_en_id = 2'b10;
    repeat (70000) @(negedge clk);
    check("sat_cnt", {16'd0, stall_cnt}, 32'hFFFF);
    check("pre_rst_err", {31'd0, sb_err}, 1);
    #2 rst = 1;
    #1 check("arst_cnt", {16'd0, stall_cnt}, 0);
    check("arst_err", {31'd0, sb_err}, 0);
    idle();
    rd_addr_id = 8'h02; rd_en_id = 2'b01;
    #1 check("arst_busy", {31'd0, stall_id}, 0);
    @(negedge clk);
    rst = 0;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter DW, default 16, datapath width.
REQ-002 Parameter AW, default 4, register address width; 2**AW registers.
REQ-003 Parameter NP, default 2, number of ID read ports.
REQ-004 Parameter ZERO_REG, default 0; when 1, address 0 never forwards, stalls or becomes busy.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 rd_addr_id  in  NP*AW  ID source addresses; port k occupies bits [k*AW +: AW].
REQ-008 rd_en_id  in  NP  per-port read valid.
REQ-009 dst_addr_ex, dst_addr_mem, dst_addr_wb  in  AW each  destination address per stage.
REQ-010 we_ex, we_mem, we_wb  in  1 each  stage will write its destination.
REQ-011 dst_ex, dst_mem, dst_wb  in  DW each  stage result data.
REQ-012 ex_is_load  in  1  EX result not available until MEM stage completes.
REQ-013 long_issue  in  1  long-latency op issuing from ID; long_issue_addr  in  AW  its destination.
REQ-014 long_done  in  1  current WB write completes a long-latency op.
REQ-015 cnt_clr  in  1  synchronous clear of stall_cnt.
REQ-016 fwd_sel  out  NP*2  per port: 0 register file, 1 EX, 2 MEM, 3 WB.
REQ-017 fwd_data  out  NP*DW  per-port forwarded value.
REQ-018 stall_id  out  1  hold ID stage and insert bubble.
REQ-019 stall_cnt  out  16  saturating count of stall cycles.
REQ-020 sb_err  out  1  sticky scoreboard protocol error.

Function
REQ-021 Per port k with rd_en_id[k]=1, priority EX > MEM > WB: first stage with we=1 and address match sets fwd_sel/fwd_data combinationally; no match gives sel 0.
REQ-022 fwd_data SHALL be 0 whenever the port's fwd_sel is 0 (never X).
REQ-023 Disabled port (rd_en_id[k]=0) SHALL output sel 0, data 0 and contribute no stall.
REQ-024 Load-use: EX match with ex_is_load=1 SHALL assert stall_id; that port's sel is still 1, but consumers ignore it while stalled.
REQ-025 Scoreboard: one busy bit per register, updated at rising clk.
REQ-026 Busy read: enabled port whose address is busy SHALL assert stall_id, unless long_done & we_wb & dst_addr_wb equals that address this cycle, in which case it forwards from WB (sel 3) without stall.
REQ-027 long_issue SHALL be accepted only when stall_id=0; an accepted issue sets busy[long_issue_addr] at next edge.
REQ-028 long_issue to an already-busy address (WAW) SHALL assert stall_id and not be accepted.
REQ-029 long_done & we_wb clears busy[dst_addr_wb] at next edge; same-cycle accepted issue to the same address leaves busy=1 (set wins).
REQ-030 long_done when busy[dst_addr_wb]=0, or with we_wb=0, SHALL set sb_err at next edge; busy unchanged.
REQ-031 stall_cnt increments by 1 each cycle stall_id=1, saturates at 16'hFFFF; cnt_clr wins over increment.

Reset
REQ-032 rst=1 SHALL asynchronously clear all busy bits, stall_cnt to 0 and sb_err to 0; reset mid-operation discards outstanding long ops.
REQ-033 Under reset with all enables low: fwd_sel=0, fwd_data=0, stall_id=0.

Structure
REQ-034 Shared package holds fwd_sel encodings (FWD_RF, FWD_EX, FWD_MEM, FWD_WB) and default DW/AW values.
REQ-035 One sub-module, fwd_port_mux, implements a single port's priority match and mux; it is instantiated NP times in a generate loop.
REQ-036 Scoreboard, stall logic and counter reside in the top level; no other registers.

Verification
REQ-037 we_ex=1, dst_addr_ex=3, dst_ex=16'hAAAA, we_mem=1, dst_addr_mem=3, rd_addr port0=3 -> sel0=1, data0=16'hAAAA, stall_id=0.
REQ-038 ex_is_load=1, dst_addr_ex=5, port1 reads 5 -> stall_id=1 for that cycle, stall_cnt increments 0->1.
REQ-039 long_issue addr 7; next cycle port0 reads 7 -> stall_id=1; long_done, we_wb=1, dst_addr_wb=7, dst_wb=16'h1234 -> sel0=3, data0=16'h1234, stall_id=0; busy[7]=0 next edge.
REQ-040 long_done with dst_addr_wb=9 not busy -> sb_err=1 next edge and stays 1 until rst.
REQ-041 ZERO_REG=1, we_ex=1, dst_addr_ex=0, port0 reads 0 -> sel0=0, data0=0; long_issue addr 0 sets no busy bit.
REQ-042 Hold stall for 70000 cycles -> stall_cnt=16'hFFFF; assert rst mid-run -> all busy, stall_cnt, sb_err cleared immediately.
